// File: rtl/ifu.sv
// ifu: instruction fetch unit, single-outstanding imem reads presented to decode via valid/ready
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HOLD, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d, req_hs, misaligned;
  assign misaligned     = pc_q[1:0] != 2'b00;
  assign imem_req_valid = state_q == REQ && !misaligned;
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign inst_valid     = state_q == HOLD;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;
  // next state, pc and captured instruction; a redirect overrides pc and picks REQ or DRAIN
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    case (state_q)
      BOOT: begin
        pc_d    = RESET_PC;
        state_d = REQ;
      end
      REQ: begin
        state_d      = misaligned ? HOLD : req_hs ? WAIT : REQ;
        inst_d       = misaligned ? NOP_INST : inst_q;
        inst_pc_d    = misaligned ? pc_q : inst_pc_q;
        inst_fault_d = misaligned ? 1'b1 : inst_fault_q;
      end
      WAIT: begin
        state_d      = imem_rsp_valid ? HOLD : WAIT;
        inst_d       = imem_rsp_valid ? (imem_rsp_err ? NOP_INST : imem_rsp_data) : inst_q;
        inst_pc_d    = imem_rsp_valid ? pc_q : inst_pc_q;
        inst_fault_d = imem_rsp_valid ? imem_rsp_err : inst_fault_q;
      end
      DRAIN: state_d = imem_rsp_valid ? REQ : DRAIN;
      HOLD: begin
        pc_d    = inst_ready ? pc_q + 32'd4 : pc_q;
        state_d = !inst_ready ? HOLD : halt ? HALT : REQ;
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = (state_q == REQ && req_hs) || ((state_q == WAIT || state_q == DRAIN) && !imem_rsp_valid) ? DRAIN : REQ;
    end
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu with a latency-configurable instruction memory model
module tb_ifu;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic [31:0] pc; logic [31:0] ins; logic f;} exp_t;
  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        inst_valid, inst_ready, inst_fault, redirect_valid, halt;
  logic [31:0] inst, inst_pc, redirect_pc;
  exp_t        sbq[$];
  logic [31:0] aq[$];
  int          n_cmp, n_err, nreq, lat, cnt, r0, hc;
  logic        pend;
  logic [31:0] paddr, err_addr;

  ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return a == 32'h8000_0000 ? 32'h0010_0093 : a == 32'h8000_0004 ? 32'h0020_0113 : a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic f);
    exp_t e;
    e.pc = pc; e.ins = ins; e.f = f;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    if (inst_valid === 1'b1 && inst_ready && !redirect_valid) begin
      if (sbq.size() == 0) chk("sb_unexp", sbq.size(), 1);
      else begin
        e = sbq.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_inst", inst, e.ins);
        chk("sb_fault", inst_fault, e.f);
      end
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      if (aq.size() != 0) chk("req_addr", imem_req_addr, aq.pop_front());
      pend = 1'b1; cnt = lat; paddr = imem_req_addr; nreq++;
    end
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = fdat(paddr);
        imem_rsp_err = paddr == err_addr;
        pend = 1'b0;
      end else cnt--;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic consume(input int budget, input string tag);
    for (int i = 0; i < budget && sbq.size() != 0; i++) tick();
    chk(tag, sbq.size(), 0);
  endtask

  task automatic wait_req(input int budget, input string tag);
    for (int i = 0; i < budget && imem_req_valid !== 1'b1; i++) tick();
    chk(tag, imem_req_valid, 1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int i = 0; i < budget && inst_valid !== 1'b1; i++) tick();
    chk(tag, inst_valid, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; nreq = 0; lat = 0; cnt = 0; pend = 1'b0; paddr = '0; err_addr = 32'h1;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", inst_fault, 0);
    rst_n = 1'b1;
    push(32'h8000_0000, 32'h0010_0093, 1'b0);
    push(32'h8000_0004, 32'h0020_0113, 1'b0);
    aq.push_back(32'h8000_0000);
    aq.push_back(32'h8000_0004);
    tick();
    chk("boot_req_valid", imem_req_valid, 1);
    chk("boot_addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk("lat2_valid", inst_valid, 0);
    tick();
    chk("lat3_valid", inst_valid, 1);
    tick();
    chk("k1_req_valid", imem_req_valid, 1);
    chk("k1_addr", imem_req_addr, 32'h8000_0004);
    tick(); tick();
    chk("thru_valid", inst_valid, 1);
    tick();
    inst_ready = 1'b0;
    imem_req_ready = 1'b0;
    redirect(32'h8000_0040);
    wait_req(10, "bp_req");
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", imem_req_addr, 32'h8000_0040);
      chk("bp_valid", imem_req_valid, 1);
      tick();
    end
    r0 = nreq;
    push(32'h8000_0040, fdat(32'h8000_0040), 1'b0);
    aq.push_back(32'h8000_0040);
    imem_req_ready = 1'b1;
    wait_valid(20, "bp_inst_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_inst", inst, fdat(32'h8000_0040));
      chk("bp_inst_pc", inst_pc, 32'h8000_0040);
      chk("bp_hold_valid", inst_valid, 1);
      tick();
    end
    inst_ready = 1'b1;
    consume(5, "bp_done");
    chk("bp_one_req", nreq - r0, 1);
    inst_ready = 1'b0;
    redirect(32'h8000_0080);
    wait_req(10, "rr_req");
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    push(32'h8000_0100, fdat(32'h8000_0100), 1'b0);
    aq.push_back(32'h8000_0100);
    inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rr_addr", imem_req_addr, 32'h8000_0100);
    consume(10, "rr_done");
    inst_ready = 1'b0;
    lat = 3;
    redirect(32'h8000_0200);
    wait_req(10, "dr_req");
    tick(); tick();
    redirect(32'h8000_0300);
    chk("dr_no_req", imem_req_valid, 0);
    push(32'h8000_0300, fdat(32'h8000_0300), 1'b0);
    aq.push_back(32'h8000_0300);
    inst_ready = 1'b1;
    consume(30, "dr_done");
    inst_ready = 1'b0;
    lat = 0;
    redirect(32'h8000_0102);
    r0 = nreq;
    push(32'h8000_0102, NOP, 1'b1);
    inst_ready = 1'b1;
    consume(10, "mis_done");
    chk("mis_no_req", nreq - r0, 0);
    inst_ready = 1'b0;
    err_addr = 32'h8000_0400;
    redirect(32'h8000_0400);
    push(32'h8000_0400, NOP, 1'b1);
    inst_ready = 1'b1;
    consume(10, "err_done");
    inst_ready = 1'b0;
    err_addr = 32'h1;
    redirect(32'h8000_0500);
    push(32'h8000_0500, fdat(32'h8000_0500), 1'b0);
    halt = 1'b1;
    inst_ready = 1'b1;
    consume(10, "halt_inst");
    inst_ready = 1'b0;
    r0 = nreq; hc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      hc += int'(imem_req_valid) + int'(inst_valid);
    end
    chk("halt_quiet", hc, 0);
    chk("halt_no_req", nreq - r0, 0);
    push(32'hFFFF_FFFC, fdat(32'hFFFF_FFFC), 1'b0);
    aq.push_back(32'hFFFF_FFFC);
    redirect(32'hFFFF_FFFC);
    halt = 1'b0;
    inst_ready = 1'b1;
    consume(10, "wrap_inst");
    inst_ready = 1'b0;
    chk("wrap_valid", imem_req_valid, 1);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    lat = 2;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mr_req_valid", imem_req_valid, 0);
    chk("mr_inst_valid", inst_valid, 0);
    chk("mr_addr", imem_req_addr, 0);
    chk("mr_inst", inst, 0);
    rst_n = 1'b1;
    push(32'h8000_0000, 32'h0010_0093, 1'b0);
    aq.push_back(32'h8000_0000);
    inst_ready = 1'b1;
    consume(20, "mr_done");
    inst_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
